// File: rtl/clk_div_gen.sv
// ---------------------------------------------------------------------------
// clk_div_gen
//
// Multi-channel clock divider / enable generator. A single free-running
// counter is shared by NUM_CH channels. Each channel selects a power-of-two
// division and produces either a 50% divided clock (mode 0) or a one-cycle
// enable pulse (mode 1). Changes of select or mode take effect only at a
// period boundary or on sync, so no runt phases appear on out_clk.
//
// Ports:
//   sys_clk  - system clock, all logic on the rising edge
//   rst      - asynchronous reset, active high
//   en       - counter advance enable
//   sync     - synchronous counter clear, forces pending changes to commit
//   sw       - per-channel requested select, channel i at sw[i*SEL_W +: SEL_W]
//   mode     - per-channel requested mode (0 = divided clock, 1 = pulse)
//   out_clk  - registered channel outputs
//   sel_act  - committed select per channel
//   pend     - high while the requested {mode, sel} differs from committed
// ---------------------------------------------------------------------------
module clk_div_gen #(
    parameter int CNT_W  = 32,
    parameter int SEL_W  = 5,
    parameter int NUM_CH = 2
) (
    input  logic                      sys_clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      sync,
    input  logic [NUM_CH*SEL_W-1:0]   sw,
    input  logic [NUM_CH-1:0]         mode,
    output logic [NUM_CH-1:0]         out_clk,
    output logic [NUM_CH*SEL_W-1:0]   sel_act,
    output logic [NUM_CH-1:0]         pend
);

    // Largest usable select: the top bit of the counter.
    localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(CNT_W - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (sync) begin
            cnt_next = '0;
        end else if (en) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [SEL_W-1:0] sw_ch;
            logic [SEL_W-1:0] eff_sel;
            logic [SEL_W-1:0] sel_act_reg;
            logic [SEL_W-1:0] max_sel;
            logic [SEL_W-1:0] sel_post;
            logic             mode_act_reg;
            logic             mode_post;
            logic             pend_raw;
            logic             at_boundary;
            logic             commit;
            logic             out_reg;
            logic             out_next;
            logic [CNT_W-1:0] max_mask;
            logic [CNT_W-1:0] post_mask;
            logic [CNT_W-1:0] cnt_shift;

            assign sw_ch   = sw[gi*SEL_W +: SEL_W];
            assign eff_sel = (32'(sw_ch) > 32'(CNT_W - 1)) ? SEL_MAX : sw_ch;

            assign pend_raw = ({mode[gi], eff_sel} != {mode_act_reg, sel_act_reg});

            // A change is safe when the slower of the old and new dividers
            // completes its period: cnt[m:0] all ones, with m the larger select.
            // Both divided clocks then fall together on this edge.
            assign max_sel     = (eff_sel > sel_act_reg) ? eff_sel : sel_act_reg;
            assign max_mask    = {CNT_W{1'b1}} >> (32'(CNT_W - 1) - 32'(max_sel));
            assign at_boundary = en && ((cnt_reg & max_mask) == max_mask);
            assign commit      = pend_raw && (sync || at_boundary);

            // Outputs follow the post-commit setting from the committing edge.
            assign sel_post  = commit ? eff_sel : sel_act_reg;
            assign mode_post = commit ? mode[gi] : mode_act_reg;
            assign post_mask = {CNT_W{1'b1}} >> (32'(CNT_W - 1) - 32'(sel_post));
            assign cnt_shift = cnt_next >> sel_post;

            always_comb begin
                out_next = cnt_shift[0];
                if (mode_post) begin
                    out_next = en && !sync && ((cnt_next & post_mask) == '0);
                end
            end

            always_ff @(posedge sys_clk or posedge rst) begin
                if (rst) begin
                    sel_act_reg  <= '0;
                    mode_act_reg <= 1'b0;
                    out_reg      <= 1'b0;
                end else begin
                    if (commit) begin
                        sel_act_reg  <= eff_sel;
                        mode_act_reg <= mode[gi];
                    end
                    out_reg <= out_next;
                end
            end

            assign out_clk[gi]                  = out_reg;
            assign sel_act[gi*SEL_W +: SEL_W]   = sel_act_reg;
            // Held low during reset even if a non-default setting is requested.
            assign pend[gi]                     = pend_raw && !rst;
        end
    endgenerate

endmodule
